muldiv_seq: RTL and testbench



---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/muldiv_seq_div_step.sv | 24 ++
 rtl/muldiv_seq.sv | 236 +++++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

    localparam int XLEN     = 32;
    localparam int DIV_ITER = 32;
    localparam int CNT_W    = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_e;

    // Two's-complement negate when neg is set; also used to take magnitudes.
    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_seq_div_step.sv
// One radix-2 restoring division iteration: shift {rem,quo} left, trial-subtract the divisor.
module div_step
    import muldiv_pkg::*;
(
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN:0]   w_sh;
    logic            w_ge;
    logic [XLEN-1:0] w_diff;

    // The shifted partial remainder can reach 33 bits, so compare at full width.
    assign w_sh   = {i_rem, i_quo[XLEN-1]};
    assign w_ge   = (w_sh >= {1'b0, i_divisor});
    assign w_diff = XLEN'(w_sh - {1'b0, i_divisor});

    assign o_rem = w_ge ? w_diff : w_sh[XLEN-1:0];
    assign o_quo = {i_quo[XLEN-2:0], w_ge};

endmodule

// File: rtl/muldiv_seq.sv
// HI/LO multiply/divide sequencer: fixed-latency multiply, iterative restoring divide,
// MTHI/MTLO writes, and a stall towards the hazard unit while an operation is in flight.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | accepting requests; MTHI/MTLO and MUL_LAT=1 multiplies finish here
//   MUL   | product held, counting down to the HI/LO write
//   DIV   | one restoring step per cycle, 32 steps
//   FIX   | apply quotient/remainder signs, write LO/HI
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int MUL_LAT = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mul_en,
    input  logic            div_en,
    input  logic            is_signed,
    input  logic            mthi,
    input  logic            mtlo,
    input  logic            mfhi,
    input  logic            mflo,
    input  logic            flush,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            busy,
    output logic            stall,
    output logic            div_by_zero
);

    md_state_e         r_state;
    md_state_e         w_state_nxt;

    logic [CNT_W-1:0]  r_cnt;
    logic [2*XLEN-1:0] r_prod;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_dvs;
    logic              r_qneg;
    logic              r_rneg;
    logic              r_dbz;

    logic              w_acc_mul;
    logic              w_acc_div;
    logic              w_acc_mthi;
    logic              w_acc_mtlo;
    logic              w_dbz;
    logic              w_mul_tick;
    logic              w_mul_wr;
    logic              w_div_step;
    logic              w_fix_wr;
    logic              w_abort;

    logic              w_rs_neg;
    logic              w_rt_neg;
    logic [XLEN-1:0]   w_rs_mag;
    logic [XLEN-1:0]   w_rt_mag;
    logic [2*XLEN-1:0] w_mul_a;
    logic [2*XLEN-1:0] w_mul_b;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_rem_nxt;
    logic [XLEN-1:0]   w_quo_nxt;

    assign w_rs_neg = is_signed & rs_val[XLEN-1];
    assign w_rt_neg = is_signed & rt_val[XLEN-1];
    assign w_rs_mag = cond_neg(rs_val, w_rs_neg);
    assign w_rt_mag = cond_neg(rt_val, w_rt_neg);

    // Sign- or zero-extend to 64 bits; the low 64 bits of the product are exact either way.
    assign w_mul_a = {{XLEN{w_rs_neg}}, rs_val};
    assign w_mul_b = {{XLEN{w_rt_neg}}, rt_val};
    assign w_prod  = w_mul_a * w_mul_b;

    div_step u_div_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_dvs),
        .o_rem     (w_rem_nxt),
        .o_quo     (w_quo_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_mul   = 1'b0;
        w_acc_div   = 1'b0;
        w_acc_mthi  = 1'b0;
        w_acc_mtlo  = 1'b0;
        w_dbz       = 1'b0;
        w_mul_tick  = 1'b0;
        w_mul_wr    = 1'b0;
        w_div_step  = 1'b0;
        w_fix_wr    = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!flush) begin
                    if (div_en) begin
                        if (rt_val == '0) begin
                            w_dbz = 1'b1;
                        end else begin
                            w_acc_div   = 1'b1;
                            w_state_nxt = ST_DIV;
                        end
                    end else if (mul_en) begin
                        w_acc_mul = 1'b1;
                        if (MUL_LAT > 1) begin
                            w_state_nxt = ST_MUL;
                        end
                    end else if (mthi) begin
                        w_acc_mthi = 1'b1;
                    end else if (mtlo) begin
                        w_acc_mtlo = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (flush) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_mul_tick = 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        w_mul_wr    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DIV: begin
                if (flush) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_div_step = 1'b1;
                    if (r_cnt == CNT_W'(DIV_ITER - 1)) begin
                        w_state_nxt = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                w_state_nxt = ST_IDLE;
                if (flush) begin
                    w_abort = 1'b1;
                end else begin
                    w_fix_wr = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_prod <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_dvs  <= '0;
            r_qneg <= 1'b0;
            r_rneg <= 1'b0;
            r_dbz  <= 1'b0;
        end else begin
            r_dbz <= w_dbz;

            if (w_acc_mul) begin
                r_prod <= w_prod;
                r_cnt  <= CNT_W'(MUL_LAT - 1);
                if (MUL_LAT == 1) begin
                    {r_hi, r_lo} <= w_prod;
                end
            end

            if (w_acc_div) begin
                r_rem  <= '0;
                r_quo  <= w_rs_mag;
                r_dvs  <= w_rt_mag;
                r_qneg <= w_rs_neg ^ w_rt_neg;
                r_rneg <= w_rs_neg;
                r_cnt  <= '0;
            end

            if (w_acc_mthi) begin
                r_hi <= rs_val;
            end
            if (w_acc_mtlo) begin
                r_lo <= rs_val;
            end

            if (w_mul_tick) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_mul_wr) begin
                {r_hi, r_lo} <= r_prod;
            end

            if (w_div_step) begin
                r_rem <= w_rem_nxt;
                r_quo <= w_quo_nxt;
                r_cnt <= r_cnt + CNT_W'(1);
            end

            // Magnitude division wraps -2^31 / -1 back to 0x80000000 with no special case.
            if (w_fix_wr) begin
                r_lo <= cond_neg(r_quo, r_qneg);
                r_hi <= cond_neg(r_rem, r_rneg);
            end

            if (w_abort) begin
                r_cnt <= '0;
            end
        end
    end

    assign hi          = r_hi;
    assign lo          = r_lo;
    assign busy        = (r_state != ST_IDLE);
    assign stall       = busy & (mul_en | div_en | mthi | mtlo | mfhi | mflo);
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq: vector table plus corner-case sequences.
module tb_muldiv_seq;

    logic        clk;
    logic        rst_n;
    logic        mul_en;
    logic        div_en;
    logic        is_signed;
    logic        mthi;
    logic        mtlo;
    logic        mfhi;
    logic        mflo;
    logic        flush;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    muldiv_seq #(.MUL_LAT(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mul_en      (mul_en),
        .div_en      (div_en),
        .is_signed   (is_signed),
        .mthi        (mthi),
        .mtlo        (mtlo),
        .mfhi        (mfhi),
        .mflo        (mflo),
        .flush       (flush),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .stall       (stall),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        is_div;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_busy;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic is_div, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, output int bcyc);
        rs_val    = a;
        rt_val    = b;
        is_signed = sgn;
        div_en    = is_div;
        mul_en    = ~is_div;
        tick();
        div_en = 1'b0;
        mul_en = 1'b0;
        bcyc   = 0;
        while (busy && bcyc < 100) begin
            bcyc++;
            tick();
        end
    endtask

    initial begin
        int bcyc;
        int n;
        int stall_cnt;
        int req_cnt;
        int pulses;

        vecs[0] = '{"mult_neg2x3",     1'b0, 1'b1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 2};
        vecs[1] = '{"multu_max",       1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 2};
        vecs[2] = '{"mult_min_sq",     1'b0, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 2};
        vecs[3] = '{"div_m7_2",        1'b1, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        vecs[4] = '{"div_min_m1",      1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
        vecs[5] = '{"div_7_m2",        1'b1, 1'b1, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
        vecs[6] = '{"divu_100_7",      1'b1, 1'b0, 32'd100,      32'd7,        32'd2,        32'd14,       33};
        vecs[7] = '{"divu_max_1",      1'b1, 1'b0, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 33};
        vecs[8] = '{"divu_min_3",      1'b1, 1'b0, 32'h80000000, 32'd3,        32'd2,        32'h2AAAAAAA, 33};
        vecs[9] = '{"div_min_3",       1'b1, 1'b1, 32'h80000000, 32'd3,        32'hFFFFFFFE, 32'hD5555556, 33};

        rst_n     = 1'b0;
        mul_en    = 1'b0;
        div_en    = 1'b0;
        is_signed = 1'b0;
        mthi      = 1'b0;
        mtlo      = 1'b0;
        mfhi      = 1'b0;
        mflo      = 1'b0;
        flush     = 1'b0;
        rs_val    = '0;
        rt_val    = '0;

        repeat (2) tick();
        check("reset_hi",    hi, 32'h0);
        check("reset_lo",    lo, 32'h0);
        check("reset_busy",  {31'b0, busy}, 32'h0);
        check("reset_stall", {31'b0, stall}, 32'h0);
        check("reset_dbz",   {31'b0, div_by_zero}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Back-to-back operations: each starts in the first IDLE cycle after the previous.
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].is_div, vecs[i].sgn, vecs[i].a, vecs[i].b, bcyc);
            check({vecs[i].name, "_hi"},   hi, vecs[i].exp_hi);
            check({vecs[i].name, "_lo"},   lo, vecs[i].exp_lo);
            check({vecs[i].name, "_busy"}, bcyc, vecs[i].exp_busy);
        end

        // Held mflo during a divide stalls until the first IDLE cycle.
        rs_val = 32'd100; rt_val = 32'd7; is_signed = 1'b0; div_en = 1'b1;
        tick();
        div_en = 1'b0;
        n = 0; stall_cnt = 0; req_cnt = 0;
        while (busy && n < 100) begin
            if (n == 4) mflo = 1'b1;
            #1;
            if (mflo) begin
                req_cnt++;
                if (stall) stall_cnt++;
            end
            tick();
            n++;
        end
        check("mflo_busy_cycles", n, 33);
        check("mflo_req_cycles", req_cnt, 29);
        check("mflo_stall_cycles", stall_cnt, 29);
        check("mflo_stall_released", {31'b0, stall}, 32'h0);
        check("mflo_lo", lo, 32'd14);
        check("mflo_hi", hi, 32'd2);
        mflo = 1'b0;
        tick();

        // Same-cycle div_en and mul_en: the divide wins.
        rs_val = 32'd100; rt_val = 32'd7; is_signed = 1'b0; div_en = 1'b1; mul_en = 1'b1;
        tick();
        div_en = 1'b0; mul_en = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
        check("prio_busy", n, 33);
        check("prio_lo", lo, 32'd14);

        // Flush in IDLE suppresses the accept.
        rs_val = 32'd5; rt_val = 32'd6; mul_en = 1'b1; flush = 1'b1;
        tick();
        mul_en = 1'b0; flush = 1'b0;
        check("idle_flush_busy", {31'b0, busy}, 32'h0);
        repeat (3) tick();
        check("idle_flush_lo", lo, 32'd14);

        // Divide by zero: no state change, one-cycle pulse, HI/LO kept.
        rs_val = 32'h11; mthi = 1'b1;
        tick();
        mthi = 1'b0; rs_val = 32'h22; mtlo = 1'b1;
        tick();
        mtlo = 1'b0;
        check("mthi_hi", hi, 32'h11);
        check("mtlo_lo", lo, 32'h22);
        rs_val = 32'd5; rt_val = 32'd0; is_signed = 1'b1; div_en = 1'b1;
        tick();
        div_en = 1'b0;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            if (div_by_zero) pulses++;
            if (busy) pulses += 100;
            tick();
        end
        check("dbz_pulses", pulses, 1);
        check("dbz_hi", hi, 32'h11);
        check("dbz_lo", lo, 32'h22);

        // Flush at divide iteration 10.
        rs_val = 32'hFFFFFFF9; rt_val = 32'd2; is_signed = 1'b1; div_en = 1'b1;
        tick();
        div_en = 1'b0;
        repeat (9) tick();
        check("flush_pre_busy", {31'b0, busy}, 32'h1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", {31'b0, busy}, 32'h0);
        repeat (30) tick();
        check("flush_hi", hi, 32'h11);
        check("flush_lo", lo, 32'h22);

        // Reset at divide iteration 20.
        rs_val = 32'hFFFFFFF9; rt_val = 32'd2; is_signed = 1'b1; div_en = 1'b1;
        tick();
        div_en = 1'b0;
        repeat (19) tick();
        check("rst_pre_busy", {31'b0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_idle_busy", {31'b0, busy}, 32'h0);

        run_op(1'b0, 1'b1, 32'd5, 32'd6, bcyc);
        check("post_rst_mult_lo", lo, 32'd30);
        check("post_rst_mult_hi", hi, 32'd0);
        check("post_rst_mult_busy", bcyc, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
